plic_target: RTL

Per-target interrupt resolver and claim/complete controller for the PLIC. It sits directly downstream of the per-source gateways. Each cycle it selects the highest-priority pending, enabled, not-in-service source and compares it against the target threshold. It drives the target interrupt line and the claim ID. It returns one-cycle claim and complete pulses to the selected gateway.

---
 rtl/plic_target.sv | 89 ++++++++
 1 files changed

// File: rtl/plic_target.sv
// PLIC per-target resolver: picks the highest-priority eligible source, gates it
// against the threshold, and tracks claim/complete through an in-service bitmap.
module plic_target #(
   parameter  int SRC_NUM    = 31,
   parameter  int PRIO_WIDTH = 3,
   localparam int ID_WIDTH   = $clog2(SRC_NUM + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [SRC_NUM-1:0]            ip_i,
   input  logic [SRC_NUM-1:0]            ie_i,
   input  logic [SRC_NUM*PRIO_WIDTH-1:0] prio_i,
   input  logic [PRIO_WIDTH-1:0]         thold_i,
   input  logic                          claim_re_i,
   input  logic                          comp_we_i,
   input  logic [ID_WIDTH-1:0]           comp_id_i,
   output logic                          irq_o,
   output logic [ID_WIDTH-1:0]           id_o,
   output logic [ID_WIDTH-1:0]           claim_id_o,
   output logic [SRC_NUM-1:0]            clam_o,
   output logic [SRC_NUM-1:0]            comp_o
);

   logic [PRIO_WIDTH-1:0] prio_arr [SRC_NUM];

   logic                  irq_q, irq_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [SRC_NUM-1:0]    ins_q, ins_d;
   logic [SRC_NUM-1:0]    clam_q, clam_d;
   logic [SRC_NUM-1:0]    comp_q, comp_d;
   logic [SRC_NUM-1:0]    set_vec, clr_vec;
   logic [ID_WIDTH-1:0]   best_id;
   logic [PRIO_WIDTH-1:0] best_prio;

   generate
      for (genvar gi = 0; gi < SRC_NUM; gi++) begin : g_prio
         assign prio_arr[gi] = prio_i[gi*PRIO_WIDTH +: PRIO_WIDTH];
      end
   endgenerate

   always_comb begin
      set_vec   = '0;
      clr_vec   = '0;
      best_id   = '0;
      best_prio = '0;
      // Decoding against every legal ID also rejects ID 0 and out-of-range IDs.
      for (int k = 0; k < SRC_NUM; k++) begin
         if (claim_re_i && irq_q && (id_q == ID_WIDTH'(k + 1)))
            set_vec[k] = 1'b1;
         if (comp_we_i && (comp_id_i == ID_WIDTH'(k + 1)) && ins_q[k])
            clr_vec[k] = 1'b1;
      end
      ins_d = (ins_q | set_vec) & ~clr_vec;
      // Strict compare in ascending order: ties keep the lowest ID, prio 0 never wins.
      for (int k = 0; k < SRC_NUM; k++) begin
         if (ip_i[k] && ie_i[k] && !ins_d[k] && (prio_arr[k] > best_prio)) begin
            best_prio = prio_arr[k];
            best_id   = ID_WIDTH'(k + 1);
         end
      end
      id_d   = best_id;
      irq_d  = (best_prio > thold_i);
      clam_d = set_vec;
      comp_d = clr_vec;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_q  <= 1'b0;
         id_q   <= '0;
         ins_q  <= '0;
         clam_q <= '0;
         comp_q <= '0;
      end else begin
         irq_q  <= irq_d;
         id_q   <= id_d;
         ins_q  <= ins_d;
         clam_q <= clam_d;
         comp_q <= comp_d;
      end
   end

   assign irq_o      = irq_q;
   assign id_o       = id_q;
   assign claim_id_o = irq_q ? id_q : '0;
   assign clam_o     = clam_q;
   assign comp_o     = comp_q;

endmodule
